// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared FSM states, halt-cause codes and the EBREAK encoding
package cpu_run_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_FIN} state_t;
  localparam logic [1:0] HC_NONE    = 2'd0;
  localparam logic [1:0] HC_EBREAK  = 2'd1;
  localparam logic [1:0] HC_TIMEOUT = 2'd2;
  localparam logic [1:0] HC_STALL   = 2'd3;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  // clear wins; otherwise count while enabled and not yet saturated
  always_ff @(posedge clk)
    if (clear) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences core reset/run phases and reports why the run halted
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RST_CYCLES    = 1,
  parameter int RUN_CYCLES    = 80,
  parameter int RESET_INJECTS = 1,
  parameter int STALL_LIMIT   = 8,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      pc_in,
  input  logic             retire_valid,
  input  logic [31:0]      retire_instr,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [7:0]       phase
);
  localparam int PMAX = RST_CYCLES > RUN_CYCLES ? RST_CYCLES : RUN_CYCLES;
  localparam int PW = $clog2(PMAX + 1);
  localparam int SW = $clog2(STALL_LIMIT + 2);
  localparam logic [PW-1:0] RST_LD = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] RUN_LD = PW'(RUN_CYCLES - 1);
  state_t state, state_n;
  logic [PW-1:0] len, len_n;
  logic [SW-1:0] stall, stall_n;
  logic [31:0] prev_pc;
  logic first, first_n, pass_n, done_n, clr, clr_cnt, ebreak, stall_hit;
  logic [1:0] hc_n;
  logic [7:0] phase_n;
  assign clr_cnt = !rst || clr;
  sat_counter #(.WIDTH(CNT_W)) u_cycles (
    .clk(clk), .clear(clr_cnt), .en(state == S_RUN), .q(cycle_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_retired (
    .clk(clk), .clear(clr_cnt), .en(state == S_RUN && retire_valid), .q(retired_cnt)
  );
  // next state, phase-length countdown, stall tracking and halt status
  always_comb begin
    state_n = state;
    len_n = len;
    stall_n = stall;
    first_n = first;
    phase_n = phase;
    pass_n = pass;
    hc_n = halt_cause;
    done_n = done;
    clr = 1'b0;
    stall_hit = 1'b0;
    ebreak = retire_valid && retire_instr == EBREAK_INSN;
    case (state)
      S_IDLE, S_FIN: if (start) begin
        state_n = S_RESET;
        len_n = RST_LD;
        clr = 1'b1;
        phase_n = '0;
        pass_n = 1'b0;
        hc_n = HC_NONE;
        done_n = 1'b0;
      end
      S_RESET: begin
        len_n = len - 1'b1;
        if (len == '0) begin
          state_n = S_RUN;
          len_n = RUN_LD;
          stall_n = '0;
          first_n = 1'b1;
        end
      end
      S_RUN: begin
        first_n = 1'b0;
        stall_n = (!first && pc_in == prev_pc) ? stall + 1'b1 : '0;
        stall_hit = STALL_LIMIT != 0 && stall_n == SW'(STALL_LIMIT);
        len_n = len - 1'b1;
        if (ebreak) begin
          state_n = S_FIN;
          pass_n = 1'b1;
          hc_n = HC_EBREAK;
          done_n = 1'b1;
        end else if (stall_hit) begin
          state_n = S_FIN;
          hc_n = HC_STALL;
          done_n = 1'b1;
        end else if (len == '0) begin
          if (int'(phase) < RESET_INJECTS) begin
            state_n = S_RESET;
            len_n = RST_LD;
            phase_n = phase + 1'b1;
          end else begin
            state_n = S_FIN;
            hc_n = HC_TIMEOUT;
            done_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  // state and fully registered outputs; the core stays in reset outside RUN
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_IDLE;
      len <= '0;
      stall <= '0;
      prev_pc <= '0;
      first <= 1'b0;
      phase <= '0;
      pass <= 1'b0;
      halt_cause <= HC_NONE;
      done <= 1'b0;
      busy <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      state <= state_n;
      len <= len_n;
      stall <= stall_n;
      first <= first_n;
      phase <= phase_n;
      pass <= pass_n;
      halt_cause <= hc_n;
      done <= done_n;
      busy <= state_n == S_RESET || state_n == S_RUN;
      cpu_rst <= state_n != S_RUN;
      if (state == S_RUN) prev_pc <= pc_in;
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: table-driven scoreboard bench for the run-sequence controller
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;
  typedef struct {
    int ebk_ph, ebk_cyc, hold_ph, hold_cyc, sp_cyc, pass, hc, cyc, ret, ph;
  } vec_t;
  typedef struct {int pass, hc, cyc, ret, ph;} exp_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, start_s = 1'b0, retire_valid = 1'b0;
  logic [31:0] pc_in = '0, retire_instr = '0;
  logic cpu_rst, busy, done, pass, cpu_rst_s, busy_s, done_s, pass_s;
  logic [1:0] halt_cause, halt_cause_s;
  logic [15:0] cycle_cnt, retired_cnt;
  logic [3:0] cycle_cnt_s, retired_cnt_s;
  logic [7:0] phase, phase_s;
  int checks = 0, failures = 0;
  exp_t sbq[$];
  vec_t vt[9];
  always #5 clk = ~clk;
  cpu_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .retire_valid(retire_valid),
    .retire_instr(retire_instr), .cpu_rst(cpu_rst), .busy(busy), .done(done), .pass(pass),
    .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .phase(phase)
  );
  cpu_run_ctrl #(.RUN_CYCLES(40), .RESET_INJECTS(0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .pc_in(pc_in), .retire_valid(retire_valid),
    .retire_instr(retire_instr), .cpu_rst(cpu_rst_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .halt_cause(halt_cause_s), .cycle_cnt(cycle_cnt_s), .retired_cnt(retired_cnt_s), .phase(phase_s)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int ph, cyc, in_rst, rs;
    bit fin, hold;
    exp_t e;
    sbq.push_back('{v.pass, v.hc, v.cyc, v.ret, v.ph});
    start = 1'b1;
    retire_valid = 1'b0;
    tick;
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_done_clr", 32'(done), 0);
    chk("start_pass_clr", 32'(pass), 0);
    chk("start_hc_clr", 32'(halt_cause), 0);
    chk("start_cyc_clr", 32'(cycle_cnt), 0);
    rs = int'(busy && cpu_rst);
    ph = 0;
    cyc = 0;
    in_rst = 1;
    fin = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      if (in_rst > 0) begin
        in_rst--;
        retire_valid = 1'b0;
        pc_in = '0;
      end else begin
        cyc++;
        if (cyc == 1) begin
          chk("phase_run", 32'(phase), ph);
          chk("cpu_rst_run", 32'(cpu_rst), 0);
        end
        hold = v.hold_ph >= 0 && (ph > v.hold_ph || (ph == v.hold_ph && cyc >= v.hold_cyc));
        pc_in = hold ? 32'h40 : 32'(32'h1000 * (ph + 1) + cyc * 4);
        retire_valid = cyc % 2 == 1;
        retire_instr = retire_valid ? 32'h0000_0073 : EBREAK_INSN;
        if (ph == v.ebk_ph && cyc == v.ebk_cyc) begin
          retire_valid = 1'b1;
          retire_instr = EBREAK_INSN;
        end
        start = ph == 0 && cyc == v.sp_cyc;
      end
      tick;
      start = 1'b0;
      if (busy && cpu_rst) rs++;
      if (done) fin = 1'b1;
      else if (in_rst == 0 && cyc == 80) begin
        ph++;
        cyc = 0;
        in_rst = 1;
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL seq_timeout: DONE not seen within bound");
      void'(sbq.pop_front());
    end else begin
      e = sbq.pop_front();
      chk("pass", 32'(pass), e.pass);
      chk("halt_cause", 32'(halt_cause), e.hc);
      chk("cycle_cnt", 32'(cycle_cnt), e.cyc);
      chk("retired_cnt", 32'(retired_cnt), e.ret);
      chk("phase_fin", 32'(phase), e.ph);
      chk("rst_pulses", rs, e.ph + 1);
      chk("busy_fin", 32'(busy), 0);
      retire_valid = 1'b1;
      retire_instr = NOP;
      repeat (3) begin
        pc_in += 4;
        tick;
      end
      chk("frz_done", 32'(done), 1);
      chk("frz_cyc", 32'(cycle_cnt), e.cyc);
      chk("frz_ret", 32'(retired_cnt), e.ret);
      chk("frz_hc", 32'(halt_cause), e.hc);
    end
    retire_valid = 1'b0;
  endtask
  initial begin
    bit fin;
    vt[0] = '{-1, 0, -1, 0, 0, 0, 2, 160, 80, 1};
    vt[1] = '{0, 25, -1, 0, 0, 1, 1, 25, 13, 0};
    vt[2] = '{-1, 0, 0, 10, 0, 0, 3, 18, 9, 0};
    vt[3] = '{1, 80, 1, 72, 0, 1, 1, 160, 81, 1};
    vt[4] = '{-1, 0, 1, 72, 0, 0, 3, 160, 80, 1};
    vt[5] = '{-1, 0, 1, 5, 0, 0, 3, 93, 47, 1};
    vt[6] = '{1, 1, -1, 0, 0, 1, 1, 81, 41, 1};
    vt[7] = '{-1, 0, 0, 1, 0, 0, 3, 9, 5, 0};
    vt[8] = '{0, 20, -1, 0, 5, 1, 1, 20, 11, 0};
    repeat (2) tick;
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_hc", 32'(halt_cause), 0);
    chk("rst_cyc", 32'(cycle_cnt), 0);
    chk("rst_phase", 32'(phase), 0);
    rst = 1'b1;
    repeat (2) tick;
    chk("idle_cpu_rst", 32'(cpu_rst), 1);
    chk("idle_busy", 32'(busy), 0);
    for (int i = 0; i < 9; i++) run_vec(vt[i]);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    repeat (10) begin
      pc_in += 4;
      retire_valid = 1'b1;
      retire_instr = NOP;
      tick;
    end
    chk("mid_pre_cyc", 32'(cycle_cnt), 10);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_cpu_rst", 32'(cpu_rst), 1);
    chk("mid_cyc", 32'(cycle_cnt), 0);
    chk("mid_ret", 32'(retired_cnt), 0);
    repeat (5) tick;
    chk("mid_no_done", 32'(done), 0);
    chk("mid_idle_busy", 32'(busy), 0);
    retire_valid = 1'b0;
    run_vec(vt[1]);
    start_s = 1'b1;
    tick;
    start_s = 1'b0;
    fin = 1'b0;
    for (int n = 0; n < 100 && !fin; n++) begin
      pc_in += 4;
      retire_valid = 1'b1;
      retire_instr = NOP;
      tick;
      if (done_s) fin = 1'b1;
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL sat_timeout: DONE not seen within bound");
    end
    chk("sat_cyc", 32'(cycle_cnt_s), 15);
    chk("sat_ret", 32'(retired_cnt_s), 15);
    chk("sat_hc", 32'(halt_cause_s), 2);
    chk("sat_pass", 32'(pass_s), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
